// File: rtl/ppu_pkg.sv
// Shared PPU bus types: access sequencer states and bus owner identities.
package ppu_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;

    // Each VRAM access is one ALE cycle followed by one STROBE cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALE    = 2'd1,
        STROBE = 2'd2
    } busState_e;

    // Which master owns the access currently on the bus.
    typedef enum logic {
        RENDER = 1'b0,
        CPU    = 1'b1
    } busOwner_e;

endpackage

// File: rtl/ppu_bus_arbiter.sv
// PPU VRAM bus arbiter: shares the multiplexed PPU_AD bus between the render
// fetch engine and CPU $2007 accesses. Render normally wins; a pending CPU
// access is forced through after STARVE_LIMIT consecutive render grants.
module ppu_bus_arbiter
    import ppu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    // render fetch port
    input  logic              rnd_req,
    input  logic [ADDR_W-1:0] rnd_addr,
    output logic              rnd_grant,
    output logic              rnd_valid,
    output logic [DATA_W-1:0] rnd_data,
    // CPU $2007 port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    // external multiplexed bus
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [DATA_W-1:0] ad_in,
    output logic [5:0]        pa_hi,
    output logic              ale,
    output logic              rd_n,
    output logic              wr_n
);

    localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    busState_e           state;
    busState_e           nextState;
    busOwner_e           owner;
    logic [ADDR_W-1:0]   busAddr;
    logic [DATA_W-1:0]   busWdata;
    logic                busWe;

    logic                pendValid;
    logic                pendWe;
    logic [ADDR_W-1:0]   pendAddr;
    logic [DATA_W-1:0]   pendWdata;
    logic                cpuBusy;
    logic [STARVE_W-1:0] starveCnt;

    logic                rndGrantQ;
    logic                rndValidQ;
    logic                cpuDoneQ;
    logic [DATA_W-1:0]   rndDataQ;
    logic [DATA_W-1:0]   cpuRdataQ;

    logic                cpuAccept;
    logic                decidePoint;
    logic                grantRender;
    logic                grantCpu;
    logic                startAccess;
    logic                accessEnd;

    // A new CPU access is only taken when nothing is pending or in flight.
    assign cpuAccept   = cpu_req && !cpuBusy;
    // Ownership is decided on the edge leaving IDLE or STROBE.
    assign decidePoint = (state == IDLE) || (state == STROBE);
    assign grantRender = decidePoint && rnd_req && !(pendValid && (starveCnt == STARVE_MAX));
    assign grantCpu    = decidePoint && !grantRender && pendValid;
    assign startAccess = grantRender || grantCpu;
    assign accessEnd   = (state == STROBE);

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic and bus pin decode from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        nextState = state;
        ale       = 1'b0;
        ad_oe     = 1'b0;
        ad_out    = '0;
        pa_hi     = '0;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        case (state)
            IDLE: begin
                if (startAccess) begin
                    nextState = ALE;
                end
            end
            ALE: begin
                ale       = 1'b1;
                ad_oe     = 1'b1;
                ad_out    = busAddr[7:0];
                pa_hi     = busAddr[13:8];
                nextState = STROBE;
            end
            STROBE: begin
                pa_hi = busAddr[13:8];
                if (busWe) begin
                    ad_oe  = 1'b1;
                    ad_out = busWdata;
                    wr_n   = 1'b0;
                end else begin
                    rd_n = 1'b0;
                end
                nextState = startAccess ? ALE : IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // One-entry CPU pending buffer: filled on acceptance, emptied on grant.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pendValid <= 1'b0;
            pendWe    <= 1'b0;
            pendAddr  <= '0;
            pendWdata <= '0;
        end else if (cpuAccept) begin
            pendValid <= 1'b1;
            pendWe    <= cpu_we;
            pendAddr  <= cpu_addr;
            pendWdata <= cpu_wdata;
        end else if (grantCpu) begin
            pendValid <= 1'b0;
        end
    end

    // CPU busy spans acceptance until the cycle after its STROBE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cpuBusy <= 1'b0;
        end else if (cpuAccept) begin
            cpuBusy <= 1'b1;
        end else if (accessEnd && (owner == CPU)) begin
            cpuBusy <= 1'b0;
        end
    end

    // Capture owner, address and write data of the access entering ALE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            owner    <= RENDER;
            busAddr  <= '0;
            busWe    <= 1'b0;
            busWdata <= '0;
        end else if (startAccess) begin
            owner    <= grantCpu ? CPU : RENDER;
            busAddr  <= grantCpu ? pendAddr : rnd_addr;
            busWe    <= grantCpu && pendWe;
            busWdata <= grantCpu ? pendWdata : '0;
        end
    end

    // Count render grants taken while the CPU waits; saturate at the limit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            starveCnt <= '0;
        end else if (grantCpu || !pendValid) begin
            starveCnt <= '0;
        end else if (grantRender && (starveCnt != STARVE_MAX)) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end

    // Handshake pulses and read data capture at the end of each STROBE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rndGrantQ <= 1'b0;
            rndValidQ <= 1'b0;
            cpuDoneQ  <= 1'b0;
            rndDataQ  <= '0;
            cpuRdataQ <= '0;
        end else begin
            rndGrantQ <= grantRender;
            rndValidQ <= accessEnd && (owner == RENDER);
            cpuDoneQ  <= accessEnd && (owner == CPU);
            if (accessEnd && !busWe) begin
                if (owner == RENDER) begin
                    rndDataQ <= ad_in;
                end else begin
                    cpuRdataQ <= ad_in;
                end
            end
        end
    end

    assign rnd_grant = rndGrantQ;
    assign rnd_valid = rndValidQ;
    assign rnd_data  = rndDataQ;
    assign cpu_busy  = cpuBusy;
    assign cpu_done  = cpuDoneQ;
    assign cpu_rdata = cpuRdataQ;

endmodule

// File: doc/ppu_bus_arbiter.md
PPU_BUS_ARBITER -- requirements
Module: ppu_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive render grants allowed while a CPU access is pending.
REQ-002 SHALL have port CLK, input, 1, PPU master clock; the single clock of the block, all state on its rising edge.
REQ-003 SHALL have port RST, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port rnd_req, input, 1, render fetch request, held until granted.
REQ-005 SHALL have port rnd_addr, input, 14, render fetch address, stable while rnd_req.
REQ-006 SHALL have port rnd_grant, output, 1, one-cycle pulse when the render address is accepted.
REQ-007 SHALL have port rnd_valid, output, 1, one-cycle pulse qualifying rnd_data.
REQ-008 SHALL have port rnd_data, output, 8, last render read byte.
REQ-009 SHALL have port cpu_req, input, 1, $2007 access request pulse.
REQ-010 SHALL have port cpu_we, input, 1, 1=write, 0=read; sampled with cpu_req.
REQ-011 SHALL have port cpu_addr, input, 14, VRAM address; sampled with cpu_req.
REQ-012 SHALL have port cpu_wdata, input, 8, write data; sampled with cpu_req.
REQ-013 SHALL have port cpu_busy, output, 1, CPU access pending or in flight.
REQ-014 SHALL have port cpu_done, output, 1, one-cycle pulse on CPU access completion.
REQ-015 SHALL have port cpu_rdata, output, 8, last CPU read byte.
REQ-016 SHALL have ports ad_out (output, 8), ad_oe (output, 1), ad_in (input, 8): multiplexed PPU_AD[7:0] drive, drive enable, sampled value.
REQ-017 SHALL have ports pa_hi (output, 6), ale (output, 1), rd_n (output, 1), wr_n (output, 1): PPU_AD[13:8], address latch enable, active-low strobes.

Function
REQ-018 SHALL implement FSM states IDLE, ALE, STROBE; each access = ALE cycle then STROBE cycle (2 CLK).
REQ-019 SHALL accept cpu_req only when cpu_busy=0, latching we/addr/wdata into a one-entry pending buffer and setting cpu_busy next cycle; cpu_req while busy SHALL be ignored.
REQ-020 SHALL select an owner on the edge leaving IDLE or STROBE when a request exists: render wins unless CPU pending and starve count = STARVE_LIMIT, then CPU wins.
REQ-021 SHALL increment starve count on each render grant while CPU pending, saturate at STARVE_LIMIT, clear to 0 when CPU granted or no CPU pending.
REQ-022 SHALL pulse rnd_grant in the cycle the render owner's address is captured (the edge entering ALE).
REQ-023 In ALE: ale=1, ad_oe=1, ad_out=addr[7:0], pa_hi=addr[13:8], rd_n=wr_n=1.
REQ-024 In STROBE read: ale=0, ad_oe=0, rd_n=0; STROBE write: ad_oe=1, ad_out=wdata, wr_n=0; pa_hi held.
REQ-025 SHALL capture ad_in at the edge ending a read STROBE into rnd_data or cpu_rdata by owner.
REQ-026 SHALL pulse rnd_valid or cpu_done (by owner) in the cycle after STROBE; cpu_busy falls in that same cycle.
REQ-027 SHALL go STROBE->ALE directly when a request exists (1 access / 2 CLK), else STROBE->IDLE; IDLE outputs: ale=0, ad_oe=0, rd_n=wr_n=1.
REQ-028 Render requests SHALL only be reads; no strobe SHALL ever assert rd_n and wr_n low together.

Reset
REQ-029 On RST low, asynchronously: state=IDLE, ale=0, ad_oe=0, rd_n=wr_n=1, ad_out=0, pa_hi=0, pulses=0, cpu_busy=0, pending dropped, starve=0, rnd_data=cpu_rdata=0.
REQ-030 Reset mid-access SHALL abort it with no done/valid pulse after release.

Structure
REQ-031 SHALL place the state enum and owner enum (RENDER, CPU) in shared package ppu_pkg.
REQ-032 SHALL be a single module; no sub-module needed.

Verification
REQ-033 CPU write 0x2345<-0xA5, idle bus -> ALE with ad_out=0x45, pa_hi=0x23; next cycle wr_n=0, ad_out=0xA5; cpu_done one cycle later.
REQ-034 CPU read 0x0010, ad_in=0x5C in STROBE -> cpu_rdata=0x5C, cpu_done pulse, cpu_busy falls same cycle.
REQ-035 rnd_req held continuously, CPU read pending -> exactly 4 render grants, then CPU access, then render resumes.
REQ-036 Back-to-back render reads 0x1000,0x1001 -> ALE/STROBE/ALE/STROBE with no IDLE cycle, two rnd_valid pulses.
REQ-037 RST low during write STROBE -> wr_n=1 immediately, no cpu_done after release, cpu_busy=0.
